// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle control unit.
// Holds instruction type/function codes, FSM state enum and datapath select codes.
package ctrl_pkg;

  // Instruction type field
  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_J = 2'b01;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_S = 2'b11;

  // R-type functions
  localparam logic [4:0] FN_R_AND = 5'd0;
  localparam logic [4:0] FN_R_ADD = 5'd1;
  localparam logic [4:0] FN_R_SUB = 5'd2;
  localparam logic [4:0] FN_R_CMP = 5'd3;

  // I-type functions
  localparam logic [4:0] FN_I_ANDI = 5'd0;
  localparam logic [4:0] FN_I_ADDI = 5'd1;
  localparam logic [4:0] FN_I_LW   = 5'd2;
  localparam logic [4:0] FN_I_SW   = 5'd3;
  localparam logic [4:0] FN_I_BEQ  = 5'd4;

  // J-type functions
  localparam logic [4:0] FN_J_J   = 5'd0;
  localparam logic [4:0] FN_J_JAL = 5'd1;

  // S-type functions
  localparam logic [4:0] FN_S_SLL  = 5'd0;
  localparam logic [4:0] FN_S_SRL  = 5'd1;
  localparam logic [4:0] FN_S_SLLV = 5'd2;
  localparam logic [4:0] FN_S_SRLV = 5'd3;

  // ALU operations
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;

  // PC source select
  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_STACK  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2 = 2'b00;
  localparam logic [1:0] SRC_B_IMM = 2'b01;
  localparam logic [1:0] SRC_B_SA  = 2'b10;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational classification of (inst_type, inst_function)
// into legality, instruction class flags and the execute-stage datapath selects.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [1:0] inst_type,
  input  logic [4:0] inst_function,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_link,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic       writes_reg
);

  // Decode table; anything not listed falls to the illegal default
  always_comb begin
    legal      = 1'b1;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_link    = 1'b0;
    alu_op     = ALU_AND;
    alu_src_b  = SRC_B_RS2;
    ext_sign   = 1'b0;
    writes_reg = 1'b0;
    case (inst_type)
      TYPE_R: begin
        writes_reg = 1'b1;
        case (inst_function)
          FN_R_AND: alu_op = ALU_AND;
          FN_R_ADD: alu_op = ALU_ADD;
          FN_R_SUB: alu_op = ALU_SUB;
          FN_R_CMP: alu_op = ALU_SUB;
          default: begin
            legal      = 1'b0;
            writes_reg = 1'b0;
          end
        endcase
      end
      TYPE_I: begin
        case (inst_function)
          FN_I_ANDI: begin
            alu_op     = ALU_AND;
            alu_src_b  = SRC_B_IMM;
            writes_reg = 1'b1;
          end
          FN_I_ADDI: begin
            alu_op     = ALU_ADD;
            alu_src_b  = SRC_B_IMM;
            ext_sign   = 1'b1;
            writes_reg = 1'b1;
          end
          FN_I_LW: begin
            alu_op     = ALU_ADD;
            alu_src_b  = SRC_B_IMM;
            ext_sign   = 1'b1;
            is_load    = 1'b1;
            writes_reg = 1'b1;
          end
          FN_I_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRC_B_IMM;
            ext_sign  = 1'b1;
            is_store  = 1'b1;
          end
          FN_I_BEQ: begin
            // compare is rs1 - rs2; the signed imm_14 feeds the branch target
            alu_op    = ALU_SUB;
            ext_sign  = 1'b1;
            is_branch = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      TYPE_J: begin
        case (inst_function)
          FN_J_J:   is_jump = 1'b1;
          FN_J_JAL: begin
            is_jump = 1'b1;
            is_link = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: begin
        writes_reg = 1'b1;
        case (inst_function)
          FN_S_SLL: begin
            alu_op    = ALU_SLL;
            alu_src_b = SRC_B_SA;
          end
          FN_S_SRL: begin
            alu_op    = ALU_SRL;
            alu_src_b = SRC_B_SA;
          end
          FN_S_SLLV: alu_op = ALU_SLL;
          FN_S_SRLV: alu_op = ALU_SRL;
          default: begin
            legal      = 1'b0;
            writes_reg = 1'b0;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the 32-bit core.
// Optional build macro ILLEGAL_TRAP_EN: illegal encodings halt the core instead of
// executing as a NOP.
//
// state | meaning
// IF    | instruction fetch, request held until mem_ready
// ID    | decode; jumps complete here, illegal encodings handled here
// EX    | ALU operation; BEQ resolves here
// MEM   | data access for LW/SW, request held until mem_ready
// WB    | register write-back and PC update
// HALT  | core stopped, only reset leaves
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] inst_type,
  input  logic [4:0] inst_function,
  input  logic       stop_bit,
  input  logic       alu_zero,
  input  logic       mem_ready,
  input  logic       stack_empty,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_inst,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       stack_push,
  output logic       stack_pop,
  output logic       reg_write,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic       wb_sel,
  output logic       halted,
  output logic       illegal,
  output logic       timeout
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       active_q;
  logic [3:0] wait_cnt_q;
  logic       wait_tc;

  logic       dec_legal, dec_load, dec_store, dec_branch, dec_jump, dec_link;
  logic       dec_ext_sign, dec_writes_reg;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_alu_src_b;

  logic       fin_halt, fin_pop;
  logic [1:0] fin_pc_src;
  state_t     fin_next;

  ctrl_decode u_decode (
    .inst_type     (inst_type),
    .inst_function (inst_function),
    .legal         (dec_legal),
    .is_load       (dec_load),
    .is_store      (dec_store),
    .is_branch     (dec_branch),
    .is_jump       (dec_jump),
    .is_link       (dec_link),
    .alu_op        (dec_alu_op),
    .alu_src_b     (dec_alu_src_b),
    .ext_sign      (dec_ext_sign),
    .writes_reg    (dec_writes_reg)
  );

  // Finish rule shared by every non-jump, non-taken instruction end
  assign fin_halt   = stop_bit & stack_empty;
  assign fin_pop    = stop_bit & ~stack_empty;
  assign fin_pc_src = fin_pop ? PC_SRC_STACK : PC_SRC_INC;
  assign fin_next   = fin_halt ? ST_HALT : ST_IF;

  assign wait_tc = (wait_cnt_q == 4'd0);

  // State register; active_q keeps all outputs quiet until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IF;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  // Memory wait down-counter: reloads on any state change, counts while a request is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if (!active_q || (state_d != state_q)) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if ((state_q == ST_IF || state_q == ST_MEM) && !mem_ready && !wait_tc) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (active_q) begin
      case (state_q)
        ST_IF: begin
          if (mem_ready)    state_d = ST_ID;
          else if (wait_tc) state_d = ST_HALT;
        end
        ST_ID: begin
          if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
            state_d = ST_HALT;
`else
            state_d = fin_next;
`endif
          end else if (dec_jump) begin
            state_d = ST_IF;
          end else begin
            state_d = ST_EX;
          end
        end
        ST_EX: begin
          if (dec_branch)                 state_d = alu_zero ? ST_IF : fin_next;
          else if (dec_load || dec_store) state_d = ST_MEM;
          else                            state_d = ST_WB;
        end
        ST_MEM: begin
          if (mem_ready)    state_d = dec_load ? ST_WB : fin_next;
          else if (wait_tc) state_d = ST_HALT;
        end
        ST_WB:   state_d = fin_next;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase
    end
  end

  // Output decode from state (branch choice and handshake completions look at inputs)
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_inst = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_INC;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    reg_write   = 1'b0;
    alu_op      = ALU_AND;
    alu_src_b   = SRC_B_RS2;
    ext_sign    = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    timeout     = 1'b0;
    if (active_q) begin
      case (state_q)
        ST_IF: begin
          mem_req     = 1'b1;
          mem_is_inst = 1'b1;
          if (mem_ready)    ir_load = 1'b1;
          else if (wait_tc) timeout = 1'b1;
        end
        ST_ID: begin
          if (!dec_legal) begin
            illegal = 1'b1;
`ifndef ILLEGAL_TRAP_EN
            pc_write  = ~fin_halt;
            pc_src    = fin_pc_src;
            stack_pop = fin_pop;
`endif
          end else if (dec_jump) begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            stack_push = dec_link;
          end
        end
        ST_EX: begin
          alu_op    = dec_alu_op;
          alu_src_b = dec_alu_src_b;
          ext_sign  = dec_ext_sign;
          if (dec_branch) begin
            if (alu_zero) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_BRANCH;
            end else begin
              pc_write  = ~fin_halt;
              pc_src    = fin_pc_src;
              stack_pop = fin_pop;
            end
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = dec_store;
          if (mem_ready) begin
            if (dec_store) begin
              pc_write  = ~fin_halt;
              pc_src    = fin_pc_src;
              stack_pop = fin_pop;
            end
          end else if (wait_tc) begin
            timeout = 1'b1;
          end
        end
        ST_WB: begin
          reg_write = dec_writes_reg;
          wb_sel    = dec_load;
          pc_write  = ~fin_halt;
          pc_src    = fin_pc_src;
          stack_pop = fin_pop;
        end
        ST_HALT: halted = 1'b1;
        default: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Each scenario pushes
// per-cycle stimulus plus expected outputs, then replays them against the DUT.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_is_inst;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       stack_push;
    logic       stack_pop;
    logic       reg_write;
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
    logic       ext_sign;
    logic       wb_sel;
    logic       halted;
    logic       illegal;
    logic       timeout;
  } out_t;

  typedef struct {
    logic [1:0] itype;
    logic [4:0] fn;
    logic       stop;
    logic       empty;
    logic       ready;
    logic       zero;
    out_t       exp;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] inst_type = 2'b00;
  logic [4:0] inst_function = 5'd0;
  logic       stop_bit = 1'b0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       stack_empty = 1'b0;
  logic       mem_req, mem_we, mem_is_inst, ir_load, pc_write, stack_push, stack_pop;
  logic       reg_write, ext_sign, wb_sel, halted, illegal, timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .inst_type(inst_type), .inst_function(inst_function),
    .stop_bit(stop_bit), .alu_zero(alu_zero), .mem_ready(mem_ready), .stack_empty(stack_empty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_inst(mem_is_inst), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .stack_push(stack_push), .stack_pop(stack_pop),
    .reg_write(reg_write), .alu_op(alu_op), .alu_src_b(alu_src_b), .ext_sign(ext_sign),
    .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic out_t get_out();
    out_t o;
    o.mem_req = mem_req;     o.mem_we = mem_we;         o.mem_is_inst = mem_is_inst;
    o.ir_load = ir_load;     o.pc_write = pc_write;     o.pc_src = pc_src;
    o.stack_push = stack_push; o.stack_pop = stack_pop; o.reg_write = reg_write;
    o.alu_op = alu_op;       o.alu_src_b = alu_src_b;   o.ext_sign = ext_sign;
    o.wb_sel = wb_sel;       o.halted = halted;         o.illegal = illegal;
    o.timeout = timeout;
    return o;
  endfunction

  function automatic out_t with_fin(input out_t e, input out_t fin);
    out_t r = e;
    r.pc_write  = fin.pc_write;
    r.pc_src    = fin.pc_src;
    r.stack_pop = fin.stack_pop;
    return r;
  endfunction

  task automatic drive(input ent_t x);
    inst_type = x.itype; inst_function = x.fn; stop_bit = x.stop;
    stack_empty = x.empty; mem_ready = x.ready; alu_zero = x.zero;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: expected per-cycle outputs of one instruction
  task automatic push_inst(input logic [1:0] t, input logic [4:0] f, input logic st,
                           input logic emp, input logic zr, input int if_w, input int mem_w,
                           output logic halts);
    out_t e, fin;
    ent_t x;
    logic legal, ld, sd, br, jmp, lnk, wr, ex;
    logic [3:0] op;
    logic [1:0] src;
    legal = 1; ld = 0; sd = 0; br = 0; jmp = 0; lnk = 0; wr = 0; ex = 0; op = 0; src = 0;
    case (t)
      2'b00: case (f)
        5'd0: wr = 1;
        5'd1: begin op = 1; wr = 1; end
        5'd2: begin op = 2; wr = 1; end
        5'd3: begin op = 2; wr = 1; end
        default: legal = 0;
      endcase
      2'b10: case (f)
        5'd0: begin src = 1; wr = 1; end
        5'd1: begin op = 1; src = 1; ex = 1; wr = 1; end
        5'd2: begin op = 1; src = 1; ex = 1; wr = 1; ld = 1; end
        5'd3: begin op = 1; src = 1; ex = 1; sd = 1; end
        5'd4: begin op = 2; ex = 1; br = 1; end
        default: legal = 0;
      endcase
      2'b01: case (f)
        5'd0: jmp = 1;
        5'd1: begin jmp = 1; lnk = 1; end
        default: legal = 0;
      endcase
      default: case (f)
        5'd0: begin op = 3; src = 2; wr = 1; end
        5'd1: begin op = 4; src = 2; wr = 1; end
        5'd2: begin op = 3; wr = 1; end
        5'd3: begin op = 4; wr = 1; end
        default: legal = 0;
      endcase
    endcase
    fin = '0;
    if (!st) fin.pc_write = 1;
    else if (!emp) begin fin.pc_write = 1; fin.pc_src = 2'b11; fin.stack_pop = 1; end
    x.itype = t; x.fn = f; x.stop = st; x.empty = emp; x.zero = zr;
    halts = st & emp;
    for (int i = 0; i <= if_w; i++) begin
      e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.ir_load = (i == if_w);
      x.ready = (i == if_w); x.exp = e; sb.push_back(x);
    end
    x.ready = 0;
    e = '0;
    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      e.illegal = 1; halts = 1;
`else
      e = with_fin(e, fin); e.illegal = 1;
`endif
      x.exp = e; sb.push_back(x);
      return;
    end
    if (jmp) begin
      e.pc_write = 1; e.pc_src = 2'b10; e.stack_push = lnk; halts = 0;
      x.exp = e; sb.push_back(x);
      return;
    end
    x.exp = e; sb.push_back(x);
    e = '0; e.alu_op = op; e.alu_src_b = src; e.ext_sign = ex;
    if (br) begin
      if (zr) begin e.pc_write = 1; e.pc_src = 2'b01; halts = 0; end
      else e = with_fin(e, fin);
      x.exp = e; sb.push_back(x);
      return;
    end
    x.exp = e; sb.push_back(x);
    if (ld || sd) begin
      for (int i = 0; i <= mem_w; i++) begin
        e = '0; e.mem_req = 1; e.mem_we = sd;
        if (i == mem_w && sd) e = with_fin(e, fin);
        x.ready = (i == mem_w); x.exp = e; sb.push_back(x);
      end
      x.ready = 0;
      if (sd) return;
    end
    e = '0; e.reg_write = wr; e.wb_sel = ld;
    e = with_fin(e, fin);
    x.exp = e; sb.push_back(x);
  endtask

  task automatic push_halt(input int n);
    ent_t x;
    x.itype = 2'b00; x.fn = 5'd1; x.stop = 0; x.empty = 0; x.zero = 0;
    x.exp = '0; x.exp.halted = 1;
    for (int i = 0; i < n; i++) begin
      x.ready = i[0];
      sb.push_back(x);
    end
  endtask

  task automatic test_reset();
    out_t got;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    got = get_out();
    n_cmp++;
    if (got !== out_t'(0)) begin n_err++; $display("FAIL reset_held: got %h expected 0", got); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = get_out();
    n_cmp++;
    if (got !== out_t'(0)) begin n_err++; $display("FAIL reset_release: got %h expected 0", got); end
  endtask

  task automatic test_alu_ops();
    ent_t x; out_t got; logic h;
    push_inst(2'b00, 5'd1, 0, 0, 0, 0, 0, h);   // ADD
    push_inst(2'b10, 5'd0, 0, 0, 0, 1, 0, h);   // ANDI, one fetch wait
    push_inst(2'b11, 5'd0, 0, 1, 0, 0, 0, h);   // SLL
    push_inst(2'b11, 5'd3, 0, 0, 0, 0, 0, h);   // SRLV
    push_inst(2'b00, 5'd3, 0, 0, 0, 14, 0, h);  // CMP, fetch ready on last allowed cycle
    push_inst(2'b10, 5'd1, 0, 0, 0, 0, 0, h);   // ADDI
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL alu_ops cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  task automatic test_load_store();
    ent_t x; out_t got; logic h;
    push_inst(2'b10, 5'd2, 0, 0, 0, 0, 3, h);   // LW, 3 memory waits
    push_inst(2'b10, 5'd3, 0, 0, 0, 2, 1, h);   // SW
    push_inst(2'b10, 5'd3, 1, 0, 0, 0, 0, h);   // SW with stop, pops
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL load_store cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  task automatic test_branch_jump();
    ent_t x; out_t got; logic h;
    push_inst(2'b10, 5'd4, 1, 1, 1, 0, 0, h);   // taken BEQ beats stop
    push_inst(2'b10, 5'd4, 0, 0, 0, 0, 0, h);   // not taken
    push_inst(2'b10, 5'd4, 1, 0, 0, 0, 0, h);   // not taken, stop pops
    push_inst(2'b01, 5'd0, 1, 1, 0, 0, 0, h);   // J ignores stop
    push_inst(2'b01, 5'd1, 1, 0, 0, 0, 0, h);   // JAL never pops
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL branch_jump cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  task automatic test_stop();
    ent_t x; out_t got; logic h;
    do_reset();
    push_inst(2'b00, 5'd2, 1, 0, 0, 0, 0, h);   // SUB stop, stack has entry
    push_inst(2'b00, 5'd2, 1, 1, 0, 0, 0, h);   // SUB stop, stack empty
    push_halt(4);
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL stop cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  task automatic test_illegal();
    ent_t x; out_t got; logic h;
    do_reset();
    push_inst(2'b01, 5'd7, 0, 0, 0, 0, 0, h);
    if (h) push_halt(2);
    else begin
      push_inst(2'b00, 5'd9, 1, 0, 0, 0, 0, h);
      push_inst(2'b00, 5'd1, 0, 0, 0, 0, 0, h);
    end
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL illegal cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  task automatic test_timeout();
    ent_t x; out_t got; logic h;
    do_reset();
    x.itype = 2'b00; x.fn = 5'd1; x.stop = 0; x.empty = 0; x.zero = 0; x.ready = 0;
    for (int i = 1; i <= 15; i++) begin
      x.exp = '0; x.exp.mem_req = 1; x.exp.mem_is_inst = 1; x.exp.timeout = (i == 15);
      sb.push_back(x);
    end
    push_halt(3);
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL if_timeout cyc%0d: got %h expected %h", c, got, x.exp); end
    end
    // Data-side timeout on a load
    do_reset();
    push_inst(2'b10, 5'd2, 0, 0, 0, 0, 0, h);
    void'(sb.pop_back());
    void'(sb.pop_back());
    x.itype = 2'b10; x.fn = 5'd2; x.ready = 0;
    for (int i = 1; i <= 15; i++) begin
      x.exp = '0; x.exp.mem_req = 1; x.exp.timeout = (i == 15);
      sb.push_back(x);
    end
    push_halt(2);
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL mem_timeout cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  task automatic test_reset_mid_mem();
    ent_t x; out_t got; logic h;
    do_reset();
    push_inst(2'b10, 5'd2, 0, 0, 0, 0, 3, h);
    // keep IF, ID, EX and the first two MEM wait cycles only
    while (sb.size() > 5) void'(sb.pop_back());
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL mid_mem_pre cyc%0d: got %h expected %h", c, got, x.exp); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = get_out();
    n_cmp++;
    if (got !== out_t'(0)) begin n_err++; $display("FAIL mid_mem_reset: got %h expected 0", got); end
    @(negedge clk);
    rst_n = 1'b1;
    push_inst(2'b00, 5'd1, 0, 0, 0, 0, 0, h);
    for (int c = 0; sb.size() > 0; c++) begin
      x = sb.pop_front();
      @(negedge clk); drive(x); #1;
      got = get_out();
      n_cmp++;
      if (got !== x.exp) begin n_err++; $display("FAIL mid_mem_refetch cyc%0d: got %h expected %h", c, got, x.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch_jump();
    test_stop();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
